// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BRANCH,
        JUMP,
        ERR
    } state_t;

    // instruction[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // alu_op
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    // alu_src_b
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // reg_dst
    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    // mem_to_reg
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // pc_src
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mem_wdt.sv
// Memory-wait watchdog: counts stalled cycles, flags the cycle whose wait reaches TIMEOUT.
// Latency: expired is combinational from the registered count and count_en.
// Backpressure: none; count_en low (memory ready) never expires, so a late ready wins.
// Ports: clk, rst_n (async active-low), count_en (stalled this cycle),
//        clear (state is changing), expired (this stalled cycle is the TIMEOUT-th).
module mem_wdt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    // The count never passes LAST: expiry forces a state change, which clears it.
    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs decode the state register.
// Backpressure: FETCH, MEM_RD and MEM_WR hold on mem_ready=0; watchdog moves to sticky ERR.
// Ports: clk, rst_n, opcode, zero, mem_ready in; datapath control strobes/selects,
//        instr_done, illegal_op and error out.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter bit          WDT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       error
);
    state_t     state, state_nxt;
    logic [5:0] op_q;
    logic       waiting, wdt_expired;
    logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s;

    assign waiting = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) && !mem_ready;

    mem_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (WDT_EN && waiting),
        .clear    (state_nxt != state),
        .expired  (wdt_expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:    if (mem_ready) state_nxt = DECODE;
                      else if (wdt_expired) state_nxt = ERR;
            DECODE:   case (opcode)
                          OP_RTYPE:         state_nxt = EXEC_R;
                          OP_ADDI, OP_SLTI: state_nxt = EXEC_I;
                          OP_LW, OP_SW:     state_nxt = MEM_ADDR;
                          OP_BEQ, OP_BNE:   state_nxt = BRANCH;
                          OP_J, OP_JAL:     state_nxt = JUMP;
                          default:          state_nxt = FETCH;
                      endcase
            MEM_ADDR: state_nxt = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) state_nxt = MEM_WB;
                      else if (wdt_expired) state_nxt = ERR;
            MEM_WR:   if (mem_ready) state_nxt = FETCH;
                      else if (wdt_expired) state_nxt = ERR;
            EXEC_R, EXEC_I: state_nxt = ALU_WB;
            MEM_WB, ALU_WB, BRANCH, JUMP: state_nxt = FETCH;
            ERR:      state_nxt = ERR;
            default:  state_nxt = FETCH;
        endcase
    end

    // Opcode is captured while in DECODE so later states ignore IR changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            op_q  <= OP_RTYPE;
        end else begin
            state <= state_nxt;
            if (state == DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        pc_write_s  = 1'b0;
        iord        = 1'b0;
        ir_write_s  = 1'b0;
        mem_read    = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        reg_dst     = DST_RT;
        mem_to_reg  = WB_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RT;
        alu_op      = ALU_ADD;
        pc_src      = PC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        error       = 1'b0;
        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                if (!(opcode inside {OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW,
                                     OP_BEQ, OP_BNE, OP_J, OP_JAL})) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = WB_MDR;
                instr_done  = 1'b1;
            end
            MEM_WR: begin
                mem_write_s = 1'b1;
                iord        = 1'b1;
                instr_done  = mem_ready;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ALU_WB: begin
                reg_write_s = 1'b1;
                reg_dst     = (op_q == OP_RTYPE) ? DST_RD : DST_RT;
                instr_done  = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                pc_write_s = (op_q == OP_BNE) ? !zero : zero;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_src     = PC_JUMP;
                pc_write_s = 1'b1;
                instr_done = 1'b1;
                if (op_q == OP_JAL) begin
                    reg_write_s = 1'b1;
                    reg_dst     = DST_R31;
                    mem_to_reg  = WB_PC;
                end
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Write strobes are masked while reset is held so FETCH+mem_ready cannot commit.
    assign pc_write  = pc_write_s  && rst_n;
    assign ir_write  = ir_write_s  && rst_n;
    assign mem_write = mem_write_s && rst_n;
    assign reg_write = reg_write_s && rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller (TIMEOUT=4, watchdog enabled).
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, iord, ir_write, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
    logic       alu_src_a, instr_done, illegal_op, error;

    int tests  = 0;
    int failed = 0;

    multicycle_controller #(.TIMEOUT(4), .WDT_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .error      (error)
    );

    always #5 clk = ~clk;

    // {pc_write, iord, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
    //  alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, error}
    logic [19:0] outs;
    assign outs = {pc_write, iord, ir_write, mem_read, mem_write, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done,
                   illegal_op, error};

    function automatic logic [19:0] enc(input logic pcw, input logic io, input logic irw,
                                        input logic mr, input logic mw, input logic rw,
                                        input logic [1:0] rd, input logic [1:0] m2r,
                                        input logic sa, input logic [1:0] sb,
                                        input logic [1:0] aop, input logic [1:0] ps,
                                        input logic dn, input logic il, input logic er);
        return {pcw, io, irw, mr, mw, rw, rd, m2r, sa, sb, aop, ps, dn, il, er};
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp);
        tests++;
        assert (outs === exp) else begin
            failed++;
            $error("FAIL %s observed=%05h expected=%05h", tag, outs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hand-built expected output words per state
    logic [19:0] x_fetch_rdy, x_fetch_wait, x_decode, x_illegal, x_mem_addr, x_mem_rd;
    logic [19:0] x_mem_wb, x_mem_wr_wait, x_mem_wr_done, x_exec_r, x_exec_addi, x_exec_slti;
    logic [19:0] x_alu_wb_r, x_alu_wb_i, x_br_take, x_br_not, x_j, x_jal, x_err;

    // FETCH with mem_ready=1, then DECODE, leaving the FSM in the state after DECODE.
    task automatic fetch_decode(input string name, input logic [5:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        #1;
        chk({name, "_fetch"}, x_fetch_rdy);
        tick;
        chk({name, "_decode"}, x_decode);
        tick;
    endtask

    initial begin
        x_fetch_rdy   = enc(1,0,1,1,0,0,2'b00,2'b00,0,2'b01,2'b00,2'b00,0,0,0);
        x_fetch_wait  = enc(0,0,0,1,0,0,2'b00,2'b00,0,2'b01,2'b00,2'b00,0,0,0);
        x_decode      = enc(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,2'b00,2'b00,0,0,0);
        x_illegal     = enc(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,2'b00,2'b00,1,1,0);
        x_mem_addr    = enc(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,2'b00,2'b00,0,0,0);
        x_mem_rd      = enc(0,1,0,1,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b00,0,0,0);
        x_mem_wb      = enc(0,0,0,0,0,1,2'b00,2'b01,0,2'b00,2'b00,2'b00,1,0,0);
        x_mem_wr_wait = enc(0,1,0,0,1,0,2'b00,2'b00,0,2'b00,2'b00,2'b00,0,0,0);
        x_mem_wr_done = enc(0,1,0,0,1,0,2'b00,2'b00,0,2'b00,2'b00,2'b00,1,0,0);
        x_exec_r      = enc(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,2'b10,2'b00,0,0,0);
        x_exec_addi   = enc(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,2'b00,2'b00,0,0,0);
        x_exec_slti   = enc(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,2'b11,2'b00,0,0,0);
        x_alu_wb_r    = enc(0,0,0,0,0,1,2'b01,2'b00,0,2'b00,2'b00,2'b00,1,0,0);
        x_alu_wb_i    = enc(0,0,0,0,0,1,2'b00,2'b00,0,2'b00,2'b00,2'b00,1,0,0);
        x_br_take     = enc(1,0,0,0,0,0,2'b00,2'b00,1,2'b00,2'b01,2'b01,1,0,0);
        x_br_not      = enc(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,2'b01,2'b01,1,0,0);
        x_j           = enc(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b10,1,0,0);
        x_jal         = enc(1,0,0,0,0,1,2'b10,2'b10,0,2'b00,2'b00,2'b10,1,0,0);
        x_err         = enc(0,0,0,0,0,0,2'b00,2'b00,0,2'b00,2'b00,2'b00,0,0,1);

        // Reset: FETCH, write strobes masked even with mem_ready high
        rst_n = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        chk("reset_fetch", x_fetch_wait);
        mem_ready = 1'b1;
        #1;
        chk("reset_masks_writes", x_fetch_wait);
        tick; tick;
        rst_n = 1'b1;

        // lw, memory always ready: FETCH DECODE MEM_ADDR MEM_RD MEM_WB
        fetch_decode("lw", 6'b100011);
        chk("lw_mem_addr", x_mem_addr);
        tick;
        chk("lw_mem_rd", x_mem_rd);
        tick;
        chk("lw_mem_wb", x_mem_wb);
        tick;

        // sw with two wait cycles in MEM_WR
        fetch_decode("sw", 6'b101011);
        chk("sw_mem_addr", x_mem_addr);
        tick;
        mem_ready = 1'b0; #1;
        chk("sw_wait0", x_mem_wr_wait);
        tick;
        chk("sw_wait1", x_mem_wr_wait);
        mem_ready = 1'b1; #1;
        chk("sw_done", x_mem_wr_done);
        tick;

        // R-type
        fetch_decode("rtype", 6'b000000);
        chk("rtype_exec", x_exec_r);
        tick;
        chk("rtype_wb", x_alu_wb_r);
        tick;

        // addi
        fetch_decode("addi", 6'b001000);
        chk("addi_exec", x_exec_addi);
        tick;
        chk("addi_wb", x_alu_wb_i);
        tick;

        // slti; IR changes to R-type after DECODE, latched opcode must still rule
        fetch_decode("slti", 6'b001010);
        opcode = 6'b000000; #1;
        chk("slti_exec_latched", x_exec_slti);
        tick;
        chk("slti_wb_latched", x_alu_wb_i);
        tick;

        // bne: zero=0 taken, zero=1 not taken (combinational on zero)
        fetch_decode("bne", 6'b000101);
        zero = 1'b0; #1;
        chk("bne_zero0", x_br_take);
        zero = 1'b1; #1;
        chk("bne_zero1", x_br_not);
        tick;

        // beq: opposite sense
        fetch_decode("beq", 6'b000100);
        zero = 1'b1; #1;
        chk("beq_zero1", x_br_take);
        zero = 1'b0; #1;
        chk("beq_zero0", x_br_not);
        tick;

        // j and jal
        fetch_decode("j", 6'b000010);
        chk("j_jump", x_j);
        tick;
        fetch_decode("jal", 6'b000011);
        chk("jal_jump", x_jal);
        tick;

        // Illegal opcode: one DECODE cycle with illegal_op, then FETCH
        opcode = 6'b111111; mem_ready = 1'b1; #1;
        chk("ill_fetch", x_fetch_rdy);
        tick;
        chk("ill_decode", x_illegal);
        tick;
        mem_ready = 1'b0; #1;
        chk("ill_back_fetch", x_fetch_wait);
        mem_ready = 1'b1;

        // Ready on the TIMEOUT-th wait cycle wins: MEM_RD -> MEM_WB
        #1;
        fetch_decode("lw_late", 6'b100011);
        tick;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("late_rd_wait", x_mem_rd);
            tick;
        end
        mem_ready = 1'b1;
        tick;
        chk("late_ready_wins", x_mem_wb);
        tick;

        // Watchdog: four stalled MEM_RD cycles then sticky ERR
        fetch_decode("lw_to", 6'b100011);
        tick;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_rd_wait", x_mem_rd);
            tick;
        end
        chk("to_err", x_err);
        mem_ready = 1'b1;
        tick; tick; tick;
        chk("err_sticky", x_err);
        rst_n = 1'b0; #1;
        chk("err_cleared_by_reset", x_fetch_wait);
        tick;
        rst_n = 1'b1;

        // Reset pulse mid-MEM_WR: mem_write drops immediately, back to FETCH
        fetch_decode("sw_rst", 6'b101011);
        tick;
        mem_ready = 1'b0; #1;
        chk("swrst_wait", x_mem_wr_wait);
        #2;
        rst_n = 1'b0; #1;
        chk("swrst_async", x_fetch_wait);
        tick;
        rst_n = 1'b1; #1;
        chk("swrst_fetch", x_fetch_wait);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
